// File: rtl/axil_timer_irq_multi_pkg.sv
// Shared constants for the multi-channel AXI4-Lite timer: register word indices, CTRL bits, responses.
// Latency: n/a (constants and a pure byte-merge helper).
// Backpressure: n/a.
package axil_timer_pkg;

    // Word indices inside the global block (byte offsets 0x00..0x0C)
    localparam logic [1:0] GLB_STATUS_IDX   = 2'd0;
    localparam logic [1:0] GLB_IRQ_EN_IDX   = 2'd1;
    localparam logic [1:0] GLB_INFO_IDX     = 2'd2;
    localparam logic [1:0] GLB_RSVD_IDX     = 2'd3;

    // Channel blocks start at 0x10 and repeat every 0x10 bytes
    localparam int         CH_BASE          = 'h10;
    localparam int         CH_STRIDE        = 'h10;

    // Word indices inside one channel block
    localparam logic [1:0] CH_CTRL_IDX      = 2'd0;
    localparam logic [1:0] CH_PERIOD_IDX    = 2'd1;
    localparam logic [1:0] CH_PRESCALE_IDX  = 2'd2;
    localparam logic [1:0] CH_COUNT_IDX     = 2'd3;

    // CTRL bit positions
    localparam int         CTRL_EN          = 0;
    localparam int         CTRL_AUTO_RELOAD = 1;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] RESP_SLVERR      = 2'b10;

    // Replace only the bytes whose strobe is set
    function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                                input logic [31:0] wr_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wr_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_timer_irq_multi_channel.sv
// One timer channel: prescaler, down-counter, EN/one-shot control, terminal pulse to the status register.
// Latency: term is combinational from the current state; it marks the edge on which STATUS must be set.
// Backpressure: none; the channel free-runs while EN is set.
module axil_timer_channel
    import axil_timer_pkg::*;
#(
    parameter int CNT_W = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_we,
    input  logic [1:0]       ctrl_wdat,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] prescale,
    output logic             en,
    output logic             auto_reload,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    logic [CNT_W-1:0] pre_cnt;
    logic             tick;
    logic             start;
    logic             stop;

    assign tick  = en && (pre_cnt == prescale);
    assign term  = tick && (count == '0);
    // Only a 0->1 transition restarts; rewriting EN=1 while running is a no-op
    assign start = ctrl_we && ctrl_wdat[CTRL_EN] && !en;
    assign stop  = ctrl_we && !ctrl_wdat[CTRL_EN];

    // Prescaler: counts 0..PRESCALE; a value already past a newly lowered PRESCALE wraps without a tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (start) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= (pre_cnt >= prescale) ? '0 : pre_cnt + 1'b1;
        end
    end

    // Down-counter: reload on start, decrement per tick, reload or hold at zero on the terminal tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (start) begin
            count <= period;
        end else if (tick) begin
            if (count != '0) begin
                count <= count - 1'b1;
            end else if (auto_reload) begin
                count <= period;
            end
        end
    end

    // EN: software write wins; hardware clears it after a one-shot terminal tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
        end else begin
            if (ctrl_we) begin
                auto_reload <= ctrl_wdat[CTRL_AUTO_RELOAD];
            end
            if (stop) begin
                en <= 1'b0;
            end else if (start) begin
                en <= 1'b1;
            end else if (term && !auto_reload) begin
                en <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axil_timer_irq_multi.sv
// AXI4-Lite multi-channel timer: register decode, W1C STATUS, IRQ_ENABLE mask, registered irq outputs.
// Latency: write response and read data one cycle after accept; irq one cycle after STATUS changes.
// Backpressure: one outstanding write and one outstanding read; ready held low while a response waits.
module axil_timer_irq_multi
    import axil_timer_pkg::*;
#(
    parameter int N_CH                 = 4,
    parameter int CNT_W                = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 8,
    parameter int C_S00_AXI_DATA_WIDTH = 32
)(
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    output logic                                irq,
    output logic [N_CH-1:0]                     irq_vec
);

    localparam int AW = C_S00_AXI_ADDR_WIDTH;
    localparam int BW = AW - 4;    // 16-byte block index: 0 = global, c+1 = channel c

    logic             wr_fire, rd_fire, wr_err, rd_err;
    logic [BW-1:0]    wr_blk, rd_blk;
    logic [1:0]       wr_word, rd_word;
    logic [N_CH-1:0]  ctrl_we, term_vec, ch_en, ch_auto, w1c_mask;
    logic [N_CH-1:0]  status_q, irq_en_q;
    logic [CNT_W-1:0] period_q   [N_CH];
    logic [CNT_W-1:0] prescale_q [N_CH];
    logic [CNT_W-1:0] ch_count   [N_CH];
    logic [31:0]      rd_dat;
    logic             unused_ok;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign wr_blk  = s00_axi_awaddr[AW-1:4];
    assign wr_word = s00_axi_awaddr[3:2];
    assign rd_blk  = s00_axi_araddr[AW-1:4];
    assign rd_word = s00_axi_araddr[3:2];
    assign wr_err  = wr_blk > BW'(N_CH);
    assign rd_err  = rd_blk > BW'(N_CH);

    // Address and data are taken together; a pending response blocks the next accept
    assign wr_fire         = s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid;
    assign s00_axi_awready = wr_fire;
    assign s00_axi_wready  = wr_fire;
    assign rd_fire         = s00_axi_arvalid && !s00_axi_rvalid;
    assign s00_axi_arready = rd_fire;

    // Per-channel CTRL strobes and the STATUS clear mask for this cycle
    always_comb begin
        ctrl_we  = '0;
        w1c_mask = '0;
        for (int c = 0; c < N_CH; c++) begin
            ctrl_we[c] = wr_fire && (wr_blk == BW'(c + 1)) && (wr_word == CH_CTRL_IDX) && s00_axi_wstrb[0];
        end
        if (wr_fire && (wr_blk == '0) && (wr_word == GLB_STATUS_IDX)) begin
            w1c_mask = N_CH'(wstrb_merge(32'd0, s00_axi_wdata, s00_axi_wstrb));
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        axil_timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk         (ACLK),
            .rst         (ARESET),
            .ctrl_we     (ctrl_we[c]),
            .ctrl_wdat   (s00_axi_wdata[1:0]),
            .period      (period_q[c]),
            .prescale    (prescale_q[c]),
            .en          (ch_en[c]),
            .auto_reload (ch_auto[c]),
            .count       (ch_count[c]),
            .term        (term_vec[c])
        );
    end

    // PERIOD/PRESCALE storage with byte strobes
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int c = 0; c < N_CH; c++) begin
                period_q[c]   <= '0;
                prescale_q[c] <= '0;
            end
        end else if (wr_fire) begin
            for (int c = 0; c < N_CH; c++) begin
                if (wr_blk == BW'(c + 1)) begin
                    if (wr_word == CH_PERIOD_IDX) begin
                        period_q[c] <= CNT_W'(wstrb_merge(32'(period_q[c]), s00_axi_wdata, s00_axi_wstrb));
                    end
                    if (wr_word == CH_PRESCALE_IDX) begin
                        prescale_q[c] <= CNT_W'(wstrb_merge(32'(prescale_q[c]), s00_axi_wdata, s00_axi_wstrb));
                    end
                end
            end
        end
    end

    // STATUS (hardware set beats W1C), IRQ_ENABLE, and the registered interrupt outputs
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            status_q <= '0;
            irq_en_q <= '0;
            irq_vec  <= '0;
            irq      <= 1'b0;
        end else begin
            status_q <= (status_q & ~w1c_mask) | term_vec;
            if (wr_fire && (wr_blk == '0) && (wr_word == GLB_IRQ_EN_IDX)) begin
                irq_en_q <= N_CH'(wstrb_merge(32'(irq_en_q), s00_axi_wdata, s00_axi_wstrb));
            end
            irq_vec <= status_q & irq_en_q;
            irq     <= |(status_q & irq_en_q);
        end
    end

    // Write response channel
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            s00_axi_bvalid <= 1'b0;
            s00_axi_bresp  <= RESP_OKAY;
        end else if (wr_fire) begin
            s00_axi_bvalid <= 1'b1;
            s00_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s00_axi_bready) begin
            s00_axi_bvalid <= 1'b0;
        end
    end

    // Read data mux; out-of-range addresses return zero
    always_comb begin
        rd_dat = '0;
        if (rd_blk == '0) begin
            case (rd_word)
                GLB_STATUS_IDX: rd_dat = 32'(status_q);
                GLB_IRQ_EN_IDX: rd_dat = 32'(irq_en_q);
                GLB_INFO_IDX:   rd_dat = {16'(CNT_W), 16'(N_CH)};
                default:        rd_dat = '0;
            endcase
        end else if (!rd_err) begin
            for (int c = 0; c < N_CH; c++) begin
                if (rd_blk == BW'(c + 1)) begin
                    case (rd_word)
                        CH_CTRL_IDX:     rd_dat = {30'd0, ch_auto[c], ch_en[c]};
                        CH_PERIOD_IDX:   rd_dat = 32'(period_q[c]);
                        CH_PRESCALE_IDX: rd_dat = 32'(prescale_q[c]);
                        default:         rd_dat = 32'(ch_count[c]);
                    endcase
                end
            end
        end
    end

    // Read response channel; data is a snapshot taken on the accept edge
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            s00_axi_rvalid <= 1'b0;
            s00_axi_rdata  <= '0;
            s00_axi_rresp  <= RESP_OKAY;
        end else if (rd_fire) begin
            s00_axi_rvalid <= 1'b1;
            s00_axi_rdata  <= rd_dat;
            s00_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_timer_irq_multi.sv
// Directed + randomized checks of the multi-channel AXI4-Lite timer against interrupt-time arithmetic.
// Latency: inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: every handshake wait is bounded.
module tb_axil_timer_irq_multi;

    localparam int N_CH = 4;
    localparam int TMO  = 20;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        irq;
    logic [N_CH-1:0] irq_vec;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_rise [N_CH];
    int last_fall [N_CH];
    logic [N_CH-1:0] prev_vec = '0;
    logic [31:0] period_m   [N_CH];
    logic [31:0] prescale_m [N_CH];

    axil_timer_irq_multi #(.N_CH(N_CH), .CNT_W(32), .C_S00_AXI_ADDR_WIDTH(8), .C_S00_AXI_DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .irq(irq), .irq_vec(irq_vec)
    );

    always #5 ACLK = ~ACLK;

    // Edge counter: after posedge k, cyc == k
    always @(posedge ACLK) cyc++;

    // Record the edge at which each irq_vec bit last rose / fell
    always @(negedge ACLK) begin
        for (int c = 0; c < N_CH; c++) begin
            if (irq_vec[c] && !prev_vec[c]) last_rise[c] = cyc;
            if (!irq_vec[c] && prev_vec[c]) last_fall[c] = cyc;
        end
        prev_vec = irq_vec;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on a falling edge with acc = accept edge number
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int acc);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        #1;
        while (!(awready && wready) && n < TMO) begin
            @(negedge ACLK); #1; n++;
        end
        @(posedge ACLK);
        @(negedge ACLK);
        acc = cyc;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < TMO) begin
            @(negedge ACLK); n++;
        end
        if (n >= TMO) begin
            checks++; errors++;
            $error("FAIL write_timeout: addr=0x%02h no bvalid", a);
        end
        resp = bresp;
        bready = 1'b1;
        @(negedge ACLK);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1'b1;
        n = 0;
        #1;
        while (!arready && n < TMO) begin
            @(negedge ACLK); #1; n++;
        end
        @(posedge ACLK);
        @(negedge ACLK);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < TMO) begin
            @(negedge ACLK); n++;
        end
        if (n >= TMO) begin
            checks++; errors++;
            $error("FAIL read_timeout: addr=0x%02h no rvalid", a);
        end
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge ACLK);
        rready = 1'b0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t - 1) @(negedge ACLK);
    endtask

    task automatic wait_rise(input int ch, input int budget);
        int n;
        n = 0;
        while (last_rise[ch] < 0 && n < budget) begin
            @(negedge ACLK); n++;
        end
    endtask

    initial begin
        logic [31:0] d, expv;
        logic [1:0]  r;
        int          acc, a0, a1, t, t2, ch, p, s;
        logic [3:0]  sb;

        for (int c = 0; c < N_CH; c++) begin
            last_rise[c] = -1; last_fall[c] = -1; period_m[c] = '0; prescale_m[c] = '0;
        end
        ARESET = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Reset state
        check("rst_awready", 32'(awready), 0);
        check("rst_wready",  32'(wready),  0);
        check("rst_arready", 32'(arready), 0);
        check("rst_bvalid",  32'(bvalid),  0);
        check("rst_rvalid",  32'(rvalid),  0);
        check("rst_rdata",   rdata,        0);
        check("rst_bresp",   32'(bresp),   0);
        check("rst_rresp",   32'(rresp),   0);
        check("rst_irq",     32'(irq),     0);
        check("rst_irq_vec", 32'(irq_vec), 0);

        axi_read(8'h08, d, r);
        check("info_data", d, 32'h0020_0004);
        check("info_resp", 32'(r), 0);
        axi_read(8'h1C, d, r);
        check("count0_rst", d, 0);

        // Ch0 auto-reload, period (3+1)*(0+1) = 4 cycles
        axi_write(8'h04, 32'h1, 4'hF, r, acc);
        axi_write(8'h14, 32'd3, 4'hF, r, acc); period_m[0] = 3;
        axi_write(8'h18, 32'd0, 4'hF, r, acc); prescale_m[0] = 0;
        last_rise[0] = -1; last_fall[0] = -1;
        axi_write(8'h10, 32'h3, 4'hF, r, a0);
        wait_rise(0, 40);
        check("ch0_first_irq_edge", 32'(last_rise[0]), 32'(a0 + 5));
        check("ch0_irq", 32'(irq), 1);

        // W1C between terminal ticks: clear seen one edge later, re-set at next period
        t = a0 + 2;
        while (t < cyc + 1) t += 4;
        wait_to(t);
        axi_write(8'h00, 32'h1, 4'hF, r, acc);
        check("w1c_accept_edge", 32'(acc), 32'(t));
        while (cyc < t + 4) @(negedge ACLK);
        check("w1c_irq_fall_edge", 32'(last_fall[0]), 32'(t + 1));
        check("ch0_reset_edge",    32'(last_rise[0]), 32'(t + 3));

        // W1C on the terminal edge: set wins, irq never drops
        t2 = a0;
        while (t2 < cyc + 1) t2 += 4;
        wait_to(t2);
        axi_write(8'h00, 32'h1, 4'hF, r, acc);
        while (cyc < t2 + 4) @(negedge ACLK);
        check("set_wins_no_fall", 32'(last_fall[0]), 32'(t + 1));
        axi_read(8'h00, d, r);
        check("set_wins_status0", d & 32'h1, 32'h1);
        axi_write(8'h10, 32'h0, 4'hF, r, acc);
        axi_write(8'h00, 32'hF, 4'hF, r, acc);

        // Ch1 one-shot, PERIOD=2 PRESCALE=4, masked
        axi_write(8'h04, 32'h0, 4'hF, r, acc);
        axi_write(8'h24, 32'd2, 4'hF, r, acc); period_m[1] = 2;
        axi_write(8'h28, 32'd4, 4'hF, r, acc); prescale_m[1] = 4;
        last_rise[1] = -1;
        axi_write(8'h20, 32'h1, 4'hF, r, a1);
        while (cyc < a1 + 25) @(negedge ACLK);
        check("masked_irq",      32'(irq),          0);
        check("masked_irq_vec",  32'(irq_vec),      0);
        check("masked_no_rise",  32'(last_rise[1]), 32'hFFFF_FFFF);
        axi_read(8'h00, d, r);
        check("oneshot_status",  d, 32'h2);
        axi_read(8'h20, d, r);
        check("oneshot_ctrl_hw_clear", d, 0);
        axi_read(8'h2C, d, r);
        check("oneshot_count", d, 0);
        axi_write(8'h04, 32'hF, 4'hF, r, acc);
        repeat (2) @(negedge ACLK);
        check("unmask_irq",     32'(irq),     1);
        check("unmask_irq_vec", 32'(irq_vec), 32'h2);
        axi_write(8'h00, 32'h2, 4'hF, r, acc);
        last_rise[1] = -1;
        axi_write(8'h20, 32'h1, 4'hF, r, a1);
        wait_rise(1, 40);
        check("oneshot_15_cycles", 32'(last_rise[1]), 32'(a1 + 16));
        axi_write(8'h00, 32'h2, 4'hF, r, acc);

        // Randomized one-shot timing and byte-strobe readback
        for (int it = 0; it < 6; it++) begin
            ch = $urandom_range(0, N_CH - 1);
            p  = $urandom_range(0, 5);
            s  = $urandom_range(0, 3);
            axi_write(8'(8'h14 + 16 * ch), 32'(p), 4'hF, r, acc); period_m[ch] = 32'(p);
            axi_write(8'(8'h18 + 16 * ch), 32'(s), 4'hF, r, acc); prescale_m[ch] = 32'(s);
            last_rise[ch] = -1;
            axi_write(8'(8'h10 + 16 * ch), 32'h1, 4'hF, r, acc);
            wait_rise(ch, 40);
            check($sformatf("rand%0d_irq_edge", it), 32'(last_rise[ch]), 32'(acc + (p + 1) * (s + 1) + 1));
            check($sformatf("rand%0d_irq", it), 32'(irq), 1);
            axi_read(8'(8'h10 + 16 * ch), d, r);
            check($sformatf("rand%0d_ctrl", it), d, 0);
            axi_read(8'(8'h1C + 16 * ch), d, r);
            check($sformatf("rand%0d_count", it), d, 0);
            axi_write(8'h00, 32'(1 << ch), 4'hF, r, acc);
            d  = $urandom;
            sb = 4'($urandom_range(1, 15));
            expv = prescale_m[ch];
            for (int b = 0; b < 4; b++) if (sb[b]) expv[8*b +: 8] = d[8*b +: 8];
            axi_write(8'(8'h18 + 16 * ch), d, sb, r, acc);
            prescale_m[ch] = expv;
            axi_read(8'(8'h18 + 16 * ch), d, r);
            check($sformatf("rand%0d_prescale_strb", it), d, expv);
        end

        // Out-of-range and reserved accesses
        axi_read(8'h50, d, r);
        check("oor_rdata", d, 0);
        check("oor_rresp", 32'(r), 32'h2);
        axi_write(8'h50, 32'h1234_5678, 4'hF, r, acc);
        check("oor_bresp", 32'(r), 32'h2);
        axi_read(8'h14, d, r);
        check("oor_no_change", d, period_m[0]);
        axi_read(8'h0C, d, r);
        check("rsvd_rdata", d, 0);
        check("rsvd_rresp", 32'(r), 0);
        axi_write(8'h34, 32'h0, 4'hF, r, acc);
        axi_write(8'h34, 32'hAABB_CCDD, 4'h1, r, acc);
        axi_read(8'h34, d, r);
        check("period2_byte0", d, 32'h0000_00DD);

        // Reset in the middle of a pending write response with ch0 running
        axi_write(8'h18, 32'd0, 4'hF, r, acc);
        axi_write(8'h14, 32'd3, 4'hF, r, acc);
        axi_write(8'h10, 32'h3, 4'hF, r, acc);
        repeat (8) @(negedge ACLK);
        check("pre_reset_irq", 32'(irq), 1);
        awaddr = 8'h04; wdata = 32'hF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        @(posedge ACLK);
        @(negedge ACLK);
        awvalid = 1'b0; wvalid = 1'b0;
        check("pending_bvalid", 32'(bvalid), 1);
        ARESET = 1'b1;
        #1;
        check("async_bvalid", 32'(bvalid), 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        repeat (5) @(negedge ACLK);
        check("post_reset_bvalid",  32'(bvalid),  0);
        check("post_reset_irq",     32'(irq),     0);
        check("post_reset_irq_vec", 32'(irq_vec), 0);
        axi_read(8'h1C, d, r);
        check("post_reset_count0", d, 0);
        axi_read(8'h10, d, r);
        check("post_reset_ctrl0", d, 0);
        axi_read(8'h00, d, r);
        check("post_reset_status", d, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
